// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter, MSB first on OQ.
// A shift register plus one holding register let back-to-back words stream
// with no gap bits. Provides an idle level, a word-start marker (FRAME) and a
// sticky underrun flag raised when the stream breaks between words.
module serial_word_tx #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic                  OQ,
    output logic                  FRAME,
    output logic                  UNDERRUN,
    input  logic                  UNDERRUN_CLR
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_v;
    logic                  busy;
    logic [CW-1:0]         cnt;
    logic                  oq_r;
    logic                  frame_r;
    logic                  underrun_r;

    logic xfer;
    logic load;

    // Ready depends only on registered state and the RST/CE pins, never on DIN_VALID.
    always_comb begin
        DIN_READY = !hold_v && !RST && CE;
        xfer      = DIN_VALID && DIN_READY;
        load      = CE && (!busy || (cnt == LAST));
    end

    assign OQ       = oq_r;
    assign FRAME    = frame_r;
    assign UNDERRUN = underrun_r;

    // Datapath: reset truncates any word in flight; CE=0 freezes everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr         <= '0;
            hold       <= '0;
            hold_v     <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            oq_r       <= IDLE_BIT;
            frame_r    <= 1'b0;
            underrun_r <= 1'b0;
        end else if (CE) begin
            // Clear first so that a same-edge set takes priority.
            if (UNDERRUN_CLR)
                underrun_r <= 1'b0;
            if (load) begin
                if (hold_v) begin
                    // HOLD is full, so ready was low and no transfer can collide here.
                    oq_r    <= hold[DATA_WIDTH-1];
                    sr      <= {hold[DATA_WIDTH-2:0], 1'b0};
                    cnt     <= '0;
                    busy    <= 1'b1;
                    frame_r <= 1'b1;
                    hold_v  <= 1'b0;
                end else if (xfer) begin
                    // Bypass: the incoming word goes straight into the shifter.
                    oq_r    <= DIN[DATA_WIDTH-1];
                    sr      <= {DIN[DATA_WIDTH-2:0], 1'b0};
                    cnt     <= '0;
                    busy    <= 1'b1;
                    frame_r <= 1'b1;
                end else begin
                    oq_r    <= IDLE_BIT;
                    busy    <= 1'b0;
                    frame_r <= 1'b0;
                    if (busy)
                        underrun_r <= 1'b1;
                end
            end else begin
                // Mid-word shift; a transfer now parks the next word in HOLD.
                oq_r    <= sr[DATA_WIDTH-1];
                sr      <= {sr[DATA_WIDTH-2:0], 1'b0};
                cnt     <= cnt + 1'b1;
                frame_r <= 1'b0;
                if (xfer) begin
                    hold   <= DIN;
                    hold_v <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: single word, streaming, loopback into a
// deserializer model, clock enable, reset mid-word, underrun set/clear race,
// and a DATA_WIDTH=2 instance streaming at full rate.
module tb_serial_word_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       oq;
    logic       frame;
    logic       underrun;
    logic       underrun_clr;

    logic [1:0] din2;
    logic       din_valid2;
    logic       din_ready2;
    logic       oq2;
    logic       frame2;
    logic       underrun2;
    logic       ce2  = 1'b1;
    logic       clr2 = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  des = 8'h00;
    logic [31:0] got_bits;
    logic [31:0] got_frames;
    logic        got_und;
    logic [7:0]  snap [0:39];

    always #5 clk = ~clk;

    serial_word_tx #(.DATA_WIDTH(8), .IDLE_BIT(1'b0)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .DIN(din), .DIN_VALID(din_valid),
        .DIN_READY(din_ready), .OQ(oq), .FRAME(frame), .UNDERRUN(underrun),
        .UNDERRUN_CLR(underrun_clr)
    );

    serial_word_tx #(.DATA_WIDTH(2), .IDLE_BIT(1'b1)) dut2 (
        .CLK(clk), .RST(rst), .CE(ce2), .DIN(din2), .DIN_VALID(din_valid2),
        .DIN_READY(din_ready2), .OQ(oq2), .FRAME(frame2), .UNDERRUN(underrun2),
        .UNDERRUN_CLR(clr2)
    );

    // Deserializer model: oldest bit ends up in the MSB ({Q8..Q1}).
    always @(posedge clk) des <= {des[6:0], oq};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_underrun;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
    endtask

    // Hold DIN_VALID high over w[0..nw-1]; record nobs cycles from the first transfer.
    task automatic run_stream(input logic [3:0][7:0] w, input int nw, input int nobs);
        int  idx = 0;
        int  n = 0;
        bit  started = 0;
        bit  fire;
        got_bits = '0; got_frames = '0; got_und = 1'b0;
        for (int c = 0; c < 200 && n < nobs; c++) begin
            din_valid = (idx < nw);
            din = (idx < nw) ? w[idx] : 8'h00;
            #1;
            fire = din_valid && din_ready;
            tick();
            if (fire) begin idx++; started = 1; end
            if (started) begin
                got_bits   = {got_bits[30:0], oq};
                got_frames = {got_frames[30:0], frame};
                got_und    = got_und | underrun;
                snap[n]    = des;
                n++;
            end
        end
        din_valid = 1'b0;
        checks++;
        if (n < nobs) begin
            errors++;
            $display("FAIL stream_timeout: observed %0d cycles, required %0d", n, nobs);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b1; din = 8'h00; din_valid = 1'b0; underrun_clr = 1'b0;
        din2 = 2'b00; din_valid2 = 1'b0;
        tick(); tick();
        checks++; if (oq !== 1'b0) begin errors++; $display("FAIL reset_oq: got %b want 0", oq); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", din_ready); end
        checks++; if (oq2 !== 1'b1) begin errors++; $display("FAIL reset_idle_bit_w2: got %b want 1", oq2); end
        rst = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", din_ready); end
    endtask

    task automatic test_single_word;
        logic [7:0] exp = 8'hA5;
        din = 8'hA5; din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (oq !== exp[7-i] || frame !== (i == 0) || underrun !== 1'b0) begin
                errors++;
                $display("FAIL single_bit%0d: got oq=%b frame=%b und=%b want oq=%b frame=%b und=0",
                         i, oq, frame, underrun, exp[7-i], (i == 0));
            end
            if (i < 7) tick();
        end
        tick();
        checks++;
        if (oq !== 1'b0 || underrun !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got oq=%b und=%b frame=%b want 0 1 0", oq, underrun, frame);
        end
        clear_underrun();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_clear: got %b want 0", underrun); end
    endtask

    task automatic test_back_to_back;
        run_stream({8'h81, 8'h00, 8'hFF, 8'h3C}, 4, 32);
        checks++; if (got_bits !== 32'h3CFF0081) begin errors++; $display("FAIL stream_bits: got %h want 3cff0081", got_bits); end
        checks++; if (got_frames !== 32'h80808080) begin errors++; $display("FAIL stream_frames: got %h want 80808080", got_frames); end
        checks++; if (got_und !== 1'b0) begin errors++; $display("FAIL stream_underrun_early: got %b want 0", got_und); end
        tick();
        checks++;
        if (oq !== 1'b0 || underrun !== 1'b1) begin
            errors++; $display("FAIL stream_end: got oq=%b und=%b want 0 1", oq, underrun);
        end
        clear_underrun();
    endtask

    task automatic test_loopback;
        run_stream({8'h00, 8'h00, 8'h5A, 8'hA5}, 2, 17);
        checks++; if (snap[8] !== 8'hA5) begin errors++; $display("FAIL loop_word0: got %h want a5", snap[8]); end
        checks++; if (snap[16] !== 8'h5A) begin errors++; $display("FAIL loop_word1: got %h want 5a", snap[16]); end
        checks++; if (got_frames[16:0] !== 17'h10100) begin errors++; $display("FAIL loop_frames: got %h want 10100", got_frames[16:0]); end
        tick();
        clear_underrun();
    endtask

    task automatic test_clock_enable;
        logic [7:0]  exp = 8'hC3;
        logic [15:0] seq = '0;
        din = 8'hC3; din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        seq = {seq[14:0], oq};
        for (int j = 1; j < 16; j++) begin
            ce = (j % 2 == 0);
            #1;
            if (!ce) begin
                checks++;
                if (din_ready !== 1'b0) begin errors++; $display("FAIL ce_ready_%0d: got %b want 0", j, din_ready); end
            end
            tick();
            seq = {seq[14:0], oq};
            if (j == 1) begin
                checks++;
                if (frame !== 1'b1) begin errors++; $display("FAIL ce_frame_hold: got %b want 1", frame); end
            end
        end
        checks++; if (seq !== 16'hF00F) begin errors++; $display("FAIL ce_sequence: got %h want f00f", seq); end
        ce = 1'b1;
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ce_underrun: got %b want 1", underrun); end
        ce = 1'b0; underrun_clr = 1'b1;
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ce_clr_ignored: got %b want 1", underrun); end
        ce = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ce_clr_applied: got %b want 0", underrun); end
    endtask

    task automatic test_reset_midword;
        din = 8'hF0; din_valid = 1'b1;
        #1;
        tick();
        din = 8'h0F;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_ready: got %b want 1", din_ready); end
        tick();
        din_valid = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_full: got %b want 0", din_ready); end
        tick(); tick();
        checks++; if (oq !== 1'b1) begin errors++; $display("FAIL rst_cnt3_bit: got %b want 1", oq); end
        rst = 1'b1;
        tick();
        checks++;
        if (oq !== 1'b0 || frame !== 1'b0 || underrun !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_midword: got oq=%b frame=%b und=%b rdy=%b want 0 0 0 0", oq, frame, underrun, din_ready);
        end
        rst = 1'b0;
        run_stream({8'h00, 8'h00, 8'h00, 8'h99}, 1, 8);
        checks++; if (got_bits[7:0] !== 8'h99) begin errors++; $display("FAIL rst_new_word: got %h want 99", got_bits[7:0]); end
        checks++; if (got_frames[7:0] !== 8'h80) begin errors++; $display("FAIL rst_new_frame: got %h want 80", got_frames[7:0]); end
        tick();
        checks++; if (oq !== 1'b0) begin errors++; $display("FAIL rst_no_stale: got %b want 0", oq); end
        clear_underrun();
    endtask

    task automatic test_underrun_race;
        run_stream({8'h00, 8'h00, 8'h00, 8'h81}, 1, 8);
        underrun_clr = 1'b1;
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b want 1", underrun); end
        tick();
        underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL race_clear_later: got %b want 0", underrun); end
    endtask

    task automatic test_width2;
        logic [2:0][1:0] w = {2'b11, 2'b01, 2'b10};
        logic [5:0] bits = '0;
        logic [5:0] frms = '0;
        int  idx = 0;
        int  n = 0;
        bit  started = 0;
        bit  fire;
        for (int c = 0; c < 50 && n < 6; c++) begin
            din_valid2 = (idx < 3);
            din2 = (idx < 3) ? w[idx] : 2'b00;
            #1;
            fire = din_valid2 && din_ready2;
            tick();
            if (fire) begin idx++; started = 1; end
            if (started) begin
                bits = {bits[4:0], oq2};
                frms = {frms[4:0], frame2};
                n++;
            end
        end
        din_valid2 = 1'b0;
        checks++; if (bits !== 6'b100111) begin errors++; $display("FAIL w2_bits: got %b want 100111", bits); end
        checks++; if (frms !== 6'b101010) begin errors++; $display("FAIL w2_frames: got %b want 101010", frms); end
        tick();
        checks++;
        if (oq2 !== 1'b1 || underrun2 !== 1'b1) begin
            errors++; $display("FAIL w2_end: got oq=%b und=%b want 1 1", oq2, underrun2);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_loopback();
        test_clock_enable();
        test_reset_midword();
        test_underrun_race();
        test_width2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
